mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data-memory store path, downstream of the single-cycle core.
- Snoops the core's ALU address, store data and store strobe every cycle.
- Captures byte stores to its TX register into a FIFO.
- Serialises each byte as 8N1 on a UART line.
- The core cannot stall, so a store arriving at a full FIFO is dropped and recorded.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values >= 2
FIFO_DEPTH, 16, byte entries in TX FIFO; power of two, >= 2
TX_ADDR, 32'hFFFF_0000, store address that enqueues wdata[7:0]
CTRL_ADDR, 32'hFFFF_0004, store address of control register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
addr  input  32  core ALU result (store address)
wdata  input  32  core store data
mem_write  input  1  core store strobe, high for the whole store cycle
tx  output  1  UART serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one byte dropped
drop_count  output  8  saturating count of dropped bytes

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release):
  - tx=1, tx_busy=0, fifo_level=0, overflow=0, drop_count=0.
  - FSM=IDLE, baud counter=0, FIFO pointers=0.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
- Decode, sampled at each rising edge:
  - push = mem_write && addr==TX_ADDR.
  - ctrl = mem_write && addr==CTRL_ADDR.
  - Other addresses are ignored.
- Push:
  - If the FIFO is not full, or a pop occurs in the same cycle, wdata[7:0] is enqueued and wdata[31:8] is ignored.
  - Otherwise the byte is dropped: overflow<=1 and drop_count increments, saturating at 255.
- Ctrl store with wdata[0]=1: overflow<=0 and drop_count<=0. A drop in the same cycle wins: overflow=1, drop_count=1.
- fifo_level: +1 on accepted push, -1 on pop, unchanged on simultaneous push+pop.
- FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1.
  - IDLE: tx=1. If FIFO non-empty: pop into 8-bit shift register, counter<=0, tx<=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0], bit index<=0, go DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7, tx<=1 and go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop and go directly to START (back-to-back, no idle gap).
    - FIFO empty: go IDLE.
- Latency:
  - Store sampled at edge E into an empty FIFO with FSM in IDLE: FIFO non-empty after E, pop at E+1, tx low from E+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx_busy = (state!=IDLE) || (fifo_level!=0), registered-consistent with the state and level registers.
- FIFO pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are distinguished by the MSB.

Decomposition:
- Package mmio_pkg holds:
  - TX_ADDR and CTRL_ADDR default constants.
  - uart_tx_state_t enum {IDLE, START, DATA, STOP}.
  - Clock/baud helper constant CLKS_PER_BIT_100M_115200 = 868.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Signals push, pop, wdata, rdata (first-word-fall-through), full, empty, level.
- The top module holds decode, overflow/drop logic and the TX FSM.

Test Plan:
- Reset then idle 100 cycles -> tx=1, tx_busy=0, fifo_level=0, overflow=0 throughout.
- CLKS_PER_BIT=4, single store addr=FFFF_0000 wdata=0x1234_55A5:
  - tx low from E+1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Then high 4 cycles; tx_busy falls after 40 cycles.
- Three consecutive store cycles 0x41, 0x42, 0x43 -> three back-to-back 40-cycle frames with no idle gap; fifo_level peaks at 2.
- FIFO_DEPTH=4, 8 consecutive stores 0x00..0x07:
  - Bytes 0x00..0x04 transmitted (first is popped immediately).
  - 3 drops: overflow=1, drop_count=3.
  - Ctrl store wdata=1 -> overflow=0, drop_count=0.
- Store to addr=FFFF_0008, and a load cycle (mem_write=0) with addr=FFFF_0000 -> no push, tx stays high.
- Assert reset low mid-DATA bit 3 -> tx=1 and fifo_level=0 the same cycle; after release a new store transmits a clean full frame.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and state type for the memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [31:0] TX_ADDR_DEFAULT          = 32'hFFFF_0000;
  localparam logic [31:0] CTRL_ADDR_DEFAULT        = 32'hFFFF_0004;
  localparam int          CLKS_PER_BIT_100M_115200 = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core store-path snoop bundle: ALU address, store data and store strobe.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;

  modport master (output addr, output wdata, output mem_write);
  modport slave  (input addr, input wdata, input mem_write);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Snoops core stores, queues bytes written to TX_ADDR and sends them as 8N1 frames.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_100M_115200,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter logic [31:0] CTRL_ADDR    = CTRL_ADDR_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  mmio_uart_tx_if.slave                 bus,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           push, ctrl_clear, pop, drop, bit_end;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic           unused_wdata_hi;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign push            = bus.mem_write && (bus.addr == TX_ADDR);
  assign ctrl_clear      = bus.mem_write && (bus.addr == CTRL_ADDR) && bus.wdata[0];
  assign drop            = push && fifo_full && !pop;
  assign unused_wdata_hi = ^bus.wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // A drop outranks a simultaneous clear so the loss is never hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= ctrl_clear ? 8'd1 : sat_inc(drop_count);
    end else if (ctrl_clear) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || (fifo_level != '0);
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode vector table, directed frame/overflow/reset sequences, random stores.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TXA   = 32'hFFFF_0000;
  localparam logic [31:0] CTA   = 32'hFFFF_0004;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx, tx_busy, overflow;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .CTRL_ADDR(CTA)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus position within the current 10-bit frame.
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;
  int         m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_drop   = 0;
    end else begin
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * CPB) begin
          if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (bus.mem_write && bus.addr == TXA) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.wdata[7:0]);
        else begin
          m_ovf  = 1'b1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end else if (bus.mem_write && bus.addr == CTA && bus.wdata[0]) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
  end

  function automatic logic model_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx, model_tx());
      check("model_busy", tx_busy, (m_active || m_q.size() != 0));
      check("model_level", fifo_level, m_q.size());
      check("model_overflow", overflow, m_ovf);
      check("model_drops", drop_count, m_drop);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.addr = a;
    bus.wdata = d;
    bus.mem_write = we;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.mem_write = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    bus.mem_write = 1'b0;
    while (tx_busy && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("wait_idle", tx_busy, 1'b0);
  endtask

  // Called just after the store edge E; checks the 40 cycles of the frame and the fall of busy.
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic [9:0] bits;
    int bad;
    bits = {1'b1, b, 1'b0};
    bad = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (tx !== bits[k / CPB]) bad++;
    end
    check({nm, "_bits_bad"}, bad, 0);
    check({nm, "_busy_last"}, tx_busy, 1'b1);
    @(posedge clk);
    #1;
    check({nm, "_busy_fall"}, tx_busy, 1'b0);
    check({nm, "_tx_idle"}, tx, 1'b1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          exp_level;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"tx_store",    32'hFFFF_0000, 32'hDEAD_BE5A, 1'b1, 1};
    vecs[1] = '{"tx_load",     32'hFFFF_0000, 32'h0000_0011, 1'b0, 0};
    vecs[2] = '{"other_addr",  32'hFFFF_0008, 32'h0000_0022, 1'b1, 0};
    vecs[3] = '{"ctrl_store",  32'hFFFF_0004, 32'h0000_0001, 1'b1, 0};
    vecs[4] = '{"near_addr",   32'hFFFF_0001, 32'h0000_0033, 1'b1, 0};
    vecs[5] = '{"tx_store_hi", 32'hFFFF_0000, 32'hFFFF_FF00, 1'b1, 1};

    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle after reset
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drops", drop_count, 0);
    idle(100);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", tx_busy, 1'b0);

    // Decode table
    foreach (vecs[i]) begin
      wait_idle(200);
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      check({vecs[i].name, "_level"}, fifo_level, vecs[i].exp_level);
      check({vecs[i].name, "_tx"}, tx, 1'b1);
      idle(2);
      check({vecs[i].name, "_txstart"}, tx, (vecs[i].exp_level != 0) ? 1'b0 : 1'b1);
    end
    wait_idle(200);

    // Single store, explicit waveform
    drive(TXA, 32'h1234_55A5, 1'b1);
    check("single_busy_rise", tx_busy, 1'b1);
    check_frame(8'hA5, "single");

    // Three back-to-back stores
    begin
      int peak, low;
      drive(TXA, 32'h41, 1'b1);
      drive(TXA, 32'h42, 1'b1);
      drive(TXA, 32'h43, 1'b1);
      peak = fifo_level;
      low = 0;
      for (int k = 3; k <= 30 * CPB; k++) begin
        @(posedge clk);
        #1;
        if (fifo_level > peak) peak = fifo_level;
        if (!tx_busy) low++;
      end
      check("b2b_peak", peak, 2);
      check("b2b_gapless", low, 0);
      @(posedge clk);
      #1;
      check("b2b_end", tx_busy, 1'b0);
    end

    // Overflow with depth 4
    for (int k = 0; k < 8; k++) drive(TXA, k, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_count, 3);
    check("ovf_level", fifo_level, 4);
    drive(CTA, 32'h1, 1'b1);
    check("clr_flag", overflow, 1'b0);
    check("clr_drops", drop_count, 0);
    wait_idle(400);

    // Drop counter saturation
    for (int k = 0; k < 300; k++) drive(TXA, k, 1'b1);
    check("sat_drops", drop_count, 255);
    check("sat_flag", overflow, 1'b1);
    drive(CTA, 32'h0, 1'b1);
    check("ctrl_bit0_zero", drop_count, 255);
    drive(CTA, 32'h1, 1'b1);
    check("sat_clear", drop_count, 0);
    wait_idle(400);

    // Reset in the middle of data bit 3
    drive(TXA, 32'h3C, 1'b1);
    drive(TXA, 32'hC3, 1'b1);
    idle(4 * CPB + 1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", tx_busy, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    drive(TXA, 32'h96, 1'b1);
    check_frame(8'h96, "postrst");

    // Random store traffic against the model
    for (int k = 0; k < 2000; k++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: drive(TXA, $urandom, 1'b1);
        4:          drive(CTA, $urandom_range(0, 3), 1'b1);
        5:          drive(32'hFFFF_0008 + ($urandom_range(0, 3) << 2), $urandom, 1'b1);
        6:          drive(TXA, $urandom, 1'b0);
        default:    idle(1);
      endcase
    end
    wait_idle(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
